// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared integer-register definitions
// Provides the default data width, the architectural register index type
// and the hardwired-zero register index.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy vector with reserve/clear arbitration
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   rsv_en, rsv_addr   mark a destination busy (instruction issued)
//   wr_en, wr_addr     writeback clears busy for that destination
//   rd_addr            NRD packed source indices to look up
//   rd_busy            per-port busy flag of the current (pre-edge) vector
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clear first, then set: a reservation landing on the same register as a
    // writeback belongs to a younger instruction, so it must survive.
    always_comb begin
        busy_d = busy_q;
        if (wr_en && (wr_addr != ZERO_IDX)) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_en && (rsv_addr != ZERO_IDX)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - NRD-read/1-write register file with busy scoreboard
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle writeback forwarding).
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   rd_en, rd_addr     read request for all ports, packed source indices
//   rd_data, rd_valid  registered operands, captured on the previous edge
//   hazard             combinational: a requested non-zero source is busy
//   rsv_en, rsv_addr   reserve a destination register
//   wr_en, wr_addr,
//   wr_data            writeback port
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic                rd_valid,
    output logic                hazard,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

    logic [XLEN-1:0]     mem_q [NREG];
    logic [XLEN-1:0]     mem_d [NREG];
    logic [NRD*XLEN-1:0] rd_data_q;
    logic [NRD*XLEN-1:0] rd_data_d;
    logic                rd_valid_q;
    logic                rd_valid_d;

    logic [NRD-1:0]      sb_busy;
    logic [NRD-1:0]      port_busy;
    logic [NRD*XLEN-1:0] read_vec;

    reg_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (sb_busy)
    );

    // Entry 0 is never written, so it stays at its reset value of zero and
    // every read of x0 returns 0 without a dedicated mux.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (wr_addr != ZERO_IDX)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [NRD-1:0] port_fwd;
    logic           wr_rsv_same;

    assign wr_rsv_same = rsv_en && (rsv_addr == wr_addr);

    // A port matching the live writeback takes wr_data directly. Its busy bit
    // is being cleared this edge, so it no longer stalls -- unless a new
    // reservation re-arms the same register in this cycle.
    always_comb begin
        port_fwd  = '0;
        port_busy = '0;
        read_vec  = '0;
        for (int i = 0; i < NRD; i++) begin
            port_fwd[i]  = wr_en && (wr_addr != ZERO_IDX)
                           && (rd_addr[i*AW +: AW] == wr_addr);
            port_busy[i] = sb_busy[i] && !(port_fwd[i] && !wr_rsv_same);
            read_vec[i*XLEN +: XLEN] = port_fwd[i] ? wr_data
                                                   : mem_q[rd_addr[i*AW +: AW]];
        end
    end
`else
    always_comb begin
        port_busy = '0;
        read_vec  = '0;
        for (int i = 0; i < NRD; i++) begin
            port_busy[i] = sb_busy[i];
            read_vec[i*XLEN +: XLEN] = mem_q[rd_addr[i*AW +: AW]];
        end
    end
`endif

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            if (rd_en && (rd_addr[i*AW +: AW] != ZERO_IDX) && port_busy[i]) begin
                hazard = 1'b1;
            end
        end
    end

    // Operands are held across stalls and idle cycles; rd_valid marks only
    // the cycle right after a successful capture.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_en && !hazard) begin
            rd_data_d  = read_vec;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;

    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        hazard;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic         b_rd_en;
    logic [15:0]  b_rd_addr;
    logic [127:0] b_rd_data;
    logic         b_rd_valid;
    logic         b_hazard;
    logic         b_rsv_en;
    logic [3:0]   b_rsv_addr;
    logic         b_wr_en;
    logic [3:0]   b_wr_addr;
    logic [31:0]  b_wr_data;

    int tests = 0;
    int fails = 0;
    bit cmp_on = 0;

    regfile_scoreboard dut (
        .clk      (clk),
        .rst      (rst_n),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .hazard   (hazard),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    regfile_scoreboard #(.XLEN(32), .NREG(16), .NRD(4)) dut4 (
        .clk      (clk),
        .rst      (rst_n),
        .rd_en    (b_rd_en),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .rd_valid (b_rd_valid),
        .hazard   (b_hazard),
        .rsv_en   (b_rsv_en),
        .rsv_addr (b_rsv_addr),
        .wr_en    (b_wr_en),
        .wr_addr  (b_wr_addr),
        .wr_data  (b_wr_data)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the 2-port default instance -----
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    logic [31:0] exp_data [2];
    logic        exp_valid;

    function automatic bit model_hazard();
        bit h = 0;
        for (int p = 0; p < 2; p++) begin
            int a = int'(rd_addr[p*5 +: 5]);
            if (a != 0 && m_busy[a]) begin
                h = 1;
`ifdef REGFILE_BYPASS_EN
                if (wr_en && int'(wr_addr) == a && !(rsv_en && rsv_addr == wr_addr))
                    h = 0;
`endif
            end
        end
        return rd_en && h;
    endfunction

    function automatic logic [31:0] model_read(int p);
        int a = int'(rd_addr[p*5 +: 5]);
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr != 0 && int'(wr_addr) == a) return wr_data;
`endif
        return m_mem[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  <= '0;
                m_busy[i] <= 0;
            end
            exp_data[0] <= '0;
            exp_data[1] <= '0;
            exp_valid   <= 0;
        end else begin
            if (rd_en && !model_hazard()) begin
                exp_data[0] <= model_read(0);
                exp_data[1] <= model_read(1);
                exp_valid   <= 1;
            end else begin
                exp_valid <= 0;
            end
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  <= wr_data;
                m_busy[wr_addr] <= 0;
            end
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] <= 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cmp_hazard", 64'(hazard), 64'(model_hazard()));
            chk("cmp_valid", 64'(rd_valid), 64'(exp_valid));
            chk("cmp_data0", 64'(rd_data[31:0]), 64'(exp_data[0]));
            chk("cmp_data1", 64'(rd_data[63:32]), 64'(exp_data[1]));
        end
    end

    // ---------------- directed stimulus ------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 0; rd_addr = '0; rsv_en = 0; rsv_addr = '0;
        wr_en = 0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
    endtask

    initial begin
        rst_n = 0;
        idle();
        b_rd_en = 0; b_rd_addr = '0; b_rsv_en = 0; b_rsv_addr = '0;
        b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0;
        step();
        cmp_on = 1;
        step();
        chk("reset_valid", 64'(rd_valid), 64'd0);
        chk("reset_data", rd_data, 64'd0);
        chk("reset_hazard", 64'(hazard), 64'd0);
        rst_n = 1;
        step();

        // NRD=4, NREG=16 instance
        b_wr_en = 1; b_wr_addr = 4'd1; b_wr_data = 32'h1;
        step();
        b_wr_addr = 4'd15; b_wr_data = 32'hF;
        step();
        b_wr_en = 0; b_rd_en = 1; b_rd_addr = {4'd0, 4'd15, 4'd1, 4'd1};
        step();
        b_rd_en = 0;
        chk("nrd4_lo", b_rd_data[63:0], {32'h1, 32'h1});
        chk("nrd4_hi", b_rd_data[127:64], {32'h0, 32'hF});
        chk("nrd4_valid", 64'(b_rd_valid), 64'd1);

        // write then read
        wr(5'd5, 32'hDEADBEEF);
        step();
        wr_en = 0; rd_en = 1; rd_addr = {5'd0, 5'd5};
        step();
        chk("wr_rd_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("wr_rd_p1", 64'(rd_data[63:32]), 64'h0);
        chk("wr_rd_valid", 64'(rd_valid), 64'd1);

        // x0 write discarded; back-to-back reads keep rd_valid high
        rd_en = 0;
        wr(5'd0, 32'h1234);
        step();
        wr_en = 0; rd_en = 1; rd_addr = {5'd0, 5'd0};
        step();
        step();
        chk("x0_read", rd_data, 64'h0);
        chk("b2b_valid", 64'(rd_valid), 64'd1);

        // scoreboard stall on x7
        rd_en = 0; rsv_en = 1; rsv_addr = 5'd7;
        step();
        rsv_en = 0; rd_en = 1; rd_addr = {5'd5, 5'd7};
        #1;
        chk("stall_hazard", 64'(hazard), 64'd1);
        step();
        chk("stall_valid", 64'(rd_valid), 64'd0);
        chk("stall_held", rd_data, 64'h0);
        wr(5'd7, 32'h55);
        step();
`ifdef REGFILE_BYPASS_EN
        wr_en = 0;
        chk("stall_byp_valid", 64'(rd_valid), 64'd1);
        chk("stall_byp_data", rd_data, {32'hDEADBEEF, 32'h55});
`else
        chk("stall_wb_valid", 64'(rd_valid), 64'd0);
        wr_en = 0;
        step();
        chk("stall_cap_valid", 64'(rd_valid), 64'd1);
        chk("stall_cap_data", rd_data, {32'hDEADBEEF, 32'h55});
`endif
        rd_en = 0;

        // reserve and writeback collide on x3: reservation wins
        rsv_en = 1; rsv_addr = 5'd3;
        wr(5'd3, 32'h33);
        step();
        idle();
        rd_en = 1; rd_addr = {5'd0, 5'd3};
        #1;
        chk("coll_hazard", 64'(hazard), 64'd1);
        rd_en = 0;
        wr(5'd3, 32'h77);
        step();
        wr_en = 0; rd_en = 1;
        step();
        chk("coll_clear", 64'(rd_data[31:0]), 64'h77);
        rd_en = 0;

        // same-cycle write and read of x9, no reservation
        wr(5'd9, 32'h1111);
        step();
        wr(5'd9, 32'hA5A5);
        rd_en = 1; rd_addr = {5'd0, 5'd9};
        step();
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle", 64'(rd_data[31:0]), 64'hA5A5);
`else
        chk("same_cycle", 64'(rd_data[31:0]), 64'h1111);
`endif
        wr_en = 0;
        step();
        chk("after_write", 64'(rd_data[31:0]), 64'hA5A5);
        rd_en = 0;

        // reset while stalled drops reservations
        rsv_en = 1; rsv_addr = 5'd1;
        step();
        rsv_addr = 5'd2;
        step();
        rsv_en = 0; rd_en = 1; rd_addr = {5'd2, 5'd1};
        #1;
        chk("rst_stall_hazard", 64'(hazard), 64'd1);
        step();
        rst_n = 0;
        #1;
        chk("rst_async_valid", 64'(rd_valid), 64'd0);
        chk("rst_async_data", rd_data, 64'h0);
        chk("rst_async_hazard", 64'(hazard), 64'd0);
        rst_n = 1;
        step();
        chk("post_rst_valid", 64'(rd_valid), 64'd1);
        chk("post_rst_data", rd_data, 64'h0);
        chk("post_rst_hazard", 64'(hazard), 64'd0);
        idle();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
